risc_core_mc: RTL and testbench
===============================

Name: risc_core_mc

Overview:
- Parametrised multi-cycle successor to the board-level toy CPU.
- Decoupled from clock division and program storage:
  - a `step` strobe advances one instruction;
  - instructions come from an external synchronous ROM port.
- Adds a full R-type ALU, BEQ/BNEQ, a hardwired-zero r0, a debug register read port and an explicit halt/reset protocol.
- Sits between the board clock divider/ROM and the LED/debug output logic.

Parameters:
- DATA_W, 16: register/ALU width; must be >= 16. Immediates are sign-extended to DATA_W.
- IMEM_AW, 4: instruction ROM word-address width. ROM depth is 2^IMEM_AW.
- PC_W, 16: PC width (byte address); must be > IMEM_AW.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- step  in  1  single-cycle strobe: start the next instruction
- imem_addr  out  IMEM_AW  ROM word address, equal to pc[IMEM_AW:1]
- imem_rdata  in  16  ROM data, valid 1 cycle after imem_addr
- busy  out  1  high while an instruction is in flight
- halted  out  1  high once HALT has executed
- pc  out  PC_W  current program counter (byte address)
- dbg_sel  in  3  debug register select
- dbg_data  out  DATA_W  combinational read of regs[dbg_sel]; 0 when dbg_sel=0
- retired  out  32  retired instruction count (see Optional Feature)

Behaviour:
- Reset (asynchronous, any state):
  - pc=0, all regs=0, state=FETCH, busy=0, halted=0, retired=0.
  - Reset mid-instruction aborts it: no register write, no PC update.
- Encoding (16-bit instruction):
  - op[15:12], rs[11:9], rt[8:6], rd[5:3], imm6[5:0], funct[2:0].
  - imm_ext = sign-extend(imm6) to DATA_W.
- FSM states: FETCH, WAIT, EXEC, HALT.
  - FETCH: busy=0. imem_addr is driven from pc. On step=1 -> WAIT (busy=1). A step arriving in any other state is ignored (not queued).
  - WAIT: ROM latency cycle; capture imem_rdata at the end of the cycle -> EXEC.
  - EXEC: decode, register write and PC update all happen in this cycle -> FETCH, or -> HALT if the instruction is HALT.
- Latency: step to architectural update = 3 clk edges. Minimum step spacing is 3 cycles.
- Instruction set:
  - 0x1 ALU, regs[rd] <= f(rs,rt) selected by funct:
    - 000 ADD
    - 001 SUB
    - 010 AND
    - 011 OR
    - 100 SLT (signed, result 1/0)
    - 101 SLTU (unsigned)
    - 110/111: no-op
  - 0x3 ADDI: regs[rt] <= regs[rs] + imm_ext.
  - 0x4 BEQ / 0x5 BNEQ:
    - taken: pc <= pc + 2 + (imm_ext << 1);
    - not taken: pc <= pc + 2.
  - 16'hFFFF HALT: halted=1, pc unchanged, retired increments. HALT state is exited only by reset.
  - Every other opcode/word is a NOP: pc += 2.
- Arithmetic and widths:
  - All arithmetic is modulo 2^DATA_W.
  - PC arithmetic is modulo 2^PC_W.
  - imem_addr takes only pc[IMEM_AW:1], so fetch wraps over ROM depth. pc[0] is always 0.
- Register file:
  - Writes to r0 are discarded; r0 always reads 0.
  - Reads in EXEC see the pre-write values, so rd==rs is well defined.
- busy=1 in WAIT and EXEC; halted=1 only in HALT.
- dbg_data reflects writes from the cycle after EXEC.

Optional Feature:
- RISC_CORE_RETIRE_CNT_EN
  - Defined: retired is a 32-bit counter, incremented in every EXEC (including HALT and NOPs). It wraps at 2^32 and is cleared by reset.
  - Undefined: retired is tied to 0 and no counter flops are synthesised.

Test Plan:
- ADDI then HALT:
  - Stimulus: ROM = {0x3045 (addi r1,r0,5), 0xFFFF}; reset; step ×2 spaced 4 cycles.
  - Response: r1=5 (dbg_sel=1), pc=2, halted=1, busy=0. With the macro defined, retired=2.
- ALU coverage:
  - Stimulus: r1=-3 and r2=4 loaded via ADDI; then ADD, SUB, AND, OR, SLT, SLTU into r3 through r7.
  - Response: r3=1, r4=0xFFF9, r5=4, r6=0xFFFD, r7(SLT)=1; an SLTU into r7 gives 0.
- Branches:
  - Stimulus: BNEQ r1,r0,-1 with r1≠0 at pc=4; then BEQ with equal operands and imm=+2.
  - Response: pc goes 4 -> 4 (self-loop on the taken BNEQ); for the BEQ, pc advances by 6. With r1=0, the BNEQ goes to pc=6.
- r0 and step-ignore:
  - Stimulus: ADDI r0,r0,7; a second step pulse asserted while busy.
  - Response: dbg_data(r0)=0; only one instruction retires, i.e. pc advances by 2 once.
- Wrap-around:
  - Stimulus: IMEM_AW=4, ROM all NOP; 17 steps.
  - Response: pc=34, imem_addr=1.
- Reset mid-instruction:
  - Stimulus: assert reset in the EXEC cycle of ADDI r1,r0,5.
  - Response: r1=0, pc=0, FSM in FETCH. After release, the instruction re-executes on the next step.

Source files
------------

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 16-bit-encoded RISC core.
// One instruction per `step` strobe, fetched from an external synchronous ROM.
// FSM: FETCH -> WAIT (ROM latency) -> EXEC (decode/write/PC update) -> FETCH | HALT.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   step            start next instruction (honoured only in FETCH)
//   imem_addr       ROM word address = pc[IMEM_AW:1]
//   imem_rdata      ROM data, valid one cycle after imem_addr
//   busy            instruction in flight (WAIT/EXEC)
//   halted          HALT executed; cleared only by reset
//   pc              program counter (byte address)
//   dbg_sel         debug register select
//   dbg_data        combinational read of regs[dbg_sel] (r0 reads 0)
//   retired         retired instruction count
//
// Optional feature macro: RISC_CORE_RETIRE_CNT_EN
//   defined   -> retired is a wrapping 32-bit count of EXEC cycles
//   undefined -> retired is tied to 0
module risc_core_mc #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IMEM_AW = 4,
  parameter int unsigned PC_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  input  logic [2:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [31:0]        retired
);

  localparam int unsigned NREG = 8;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_q;
  logic [15:0]         ir_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic                busy_q;
  logic                halted_q;

  // Instruction fields
  logic [3:0]          op;
  logic [2:0]          rs_a;
  logic [2:0]          rt_a;
  logic [2:0]          rd_a;
  logic [2:0]          funct;
  logic [5:0]          imm6;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   rt_val;
  logic [DATA_W-1:0]   imm_ext;
  logic [PC_W-1:0]     br_off;
  logic                is_halt;

  // Execute-stage next values
  logic [PC_W-1:0]     pc_d;
  logic                wr_en_d;
  logic [2:0]          wr_addr_d;
  logic [DATA_W-1:0]   wr_data_d;

  assign op      = ir_q[15:12];
  assign rs_a    = ir_q[11:9];
  assign rt_a    = ir_q[8:6];
  assign rd_a    = ir_q[5:3];
  assign funct   = ir_q[2:0];
  assign imm6    = ir_q[5:0];
  assign rs_val  = regs_q[rs_a];
  assign rt_val  = regs_q[rt_a];
  assign imm_ext = {{(DATA_W-6){imm6[5]}}, imm6};
  assign br_off  = {{(PC_W-6){imm6[5]}}, imm6};
  assign is_halt = (ir_q == 16'hFFFF);

  // Decode/execute: reads see pre-write register values
  always_comb begin
    pc_d      = pc_q + PC_W'(2);
    wr_en_d   = 1'b0;
    wr_addr_d = rd_a;
    wr_data_d = '0;
    if (is_halt) begin
      pc_d = pc_q;
    end else begin
      case (op)
        4'h1: begin
          wr_en_d = 1'b1;
          case (funct)
            3'd0:    wr_data_d = rs_val + rt_val;
            3'd1:    wr_data_d = rs_val - rt_val;
            3'd2:    wr_data_d = rs_val & rt_val;
            3'd3:    wr_data_d = rs_val | rt_val;
            3'd4:    wr_data_d = DATA_W'($signed(rs_val) < $signed(rt_val));
            3'd5:    wr_data_d = DATA_W'(rs_val < rt_val);
            default: wr_en_d   = 1'b0;
          endcase
        end
        4'h3: begin
          wr_en_d   = 1'b1;
          wr_addr_d = rt_a;
          wr_data_d = rs_val + imm_ext;
        end
        4'h4: if (rs_val == rt_val) pc_d = pc_q + PC_W'(2) + (br_off << 1);
        4'h5: if (rs_val != rt_val) pc_d = pc_q + PC_W'(2) + (br_off << 1);
        default: ;
      endcase
    end
  end

  // Control FSM and architectural state; async reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (step) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          ir_q    <= imem_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          pc_q   <= pc_d;
          busy_q <= 1'b0;
          // r0 is hardwired to zero
          if (wr_en_d && (wr_addr_d != 3'd0)) regs_q[wr_addr_d] <= wr_data_d;
          if (is_halt) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
          end
        end
        S_HALT: state_q <= S_HALT;
      endcase
    end
  end

`ifdef RISC_CORE_RETIRE_CNT_EN
  logic [31:0] retired_q;

  // One retirement per EXEC cycle, HALT and NOPs included
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state_q == S_EXEC) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

  assign imem_addr = pc_q[IMEM_AW:1];
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign pc        = pc_q;
  assign dbg_data  = regs_q[dbg_sel];

endmodule

// File: tb/tb_risc_core_mc.sv
// Testbench for risc_core_mc: instruction-level ISA model compared every cycle,
// plus directed programs with hand-computed literal results.
module tb_risc_core_mc;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          step = 1'b0;
  logic [2:0]    dbg_sel = 3'd0;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          busy;
  logic          halted;
  logic [PW-1:0] pc;
  logic [DW-1:0] dbg_data;
  logic [31:0]   retired;

  logic [15:0]   rom [16];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  risc_core_mc #(.DATA_W(DW), .IMEM_AW(AW), .PC_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .retired    (retired)
  );

  // Synchronous ROM, one cycle latency
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // ---------------- ISA model ----------------
  logic [15:0]  m_regs [8];
  logic [15:0]  m_pc;
  bit           m_halted;
  bit           m_busy;
  int unsigned  m_retired;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    m_pc = 16'd0;
    m_halted = 1'b0;
    m_busy = 1'b0;
    m_retired = 0;
  endfunction

  function automatic void model_exec();
    logic [15:0] w, a, b;
    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, fn;
    int          imm;
    w  = rom[m_pc[4:1]];
    op = w[15:12]; rs = w[11:9]; rt = w[8:6]; rd = w[5:3]; fn = w[2:0];
    imm = $signed(w[5:0]);
    a = m_regs[rs];
    b = m_regs[rt];
    m_retired++;
    if (w == 16'hFFFF) begin
      m_halted = 1'b1;
      return;
    end
    m_pc = m_pc + 16'd2;
    case (op)
      4'h1: if (rd != 3'd0) begin
        case (fn)
          3'd0: m_regs[rd] = a + b;
          3'd1: m_regs[rd] = a - b;
          3'd2: m_regs[rd] = a & b;
          3'd3: m_regs[rd] = a | b;
          3'd4: m_regs[rd] = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          3'd5: m_regs[rd] = (a < b) ? 16'd1 : 16'd0;
          default: ;
        endcase
      end
      4'h3: if (rt != 3'd0) m_regs[rt] = a + 16'(imm);
      4'h4: if (a == b) m_pc = 16'(int'(m_pc) + 2 * imm);
      4'h5: if (a != b) m_pc = 16'(int'(m_pc) + 2 * imm);
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] exp_retired();
`ifdef RISC_CORE_RETIRE_CNT_EN
    return 32'(m_retired);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc",        32'(pc),        32'(m_pc));
      chk("busy",      32'(busy),      32'(m_busy));
      chk("halted",    32'(halted),    32'(m_halted));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[4:1]));
      chk("dbg_data",  32'(dbg_data),  32'(m_regs[dbg_sel]));
      chk("retired",   retired,        exp_retired());
    end
  end

  // Debug select sweeps all registers unless a directed peek pins it
  bit         frc_en = 1'b0;
  logic [2:0] frc_val = 3'd0;

  always @(posedge clk) begin
    #1;
    dbg_sel = frc_en ? frc_val : dbg_sel + 3'd1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // extra: pulse step again while in WAIT; abort: assert reset during EXEC
  task automatic do_step(input bit extra, input bit abort);
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    if (!m_halted) m_busy = 1'b1;
    if (extra) step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    if (abort) begin
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1 reset = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (m_busy) begin
      model_exec();
      m_busy = 1'b0;
    end
  endtask

  task automatic peek(input string name, input logic [2:0] sel, input logic [15:0] exp);
    frc_val = sel;
    frc_en  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(name, 32'(dbg_data), 32'(exp));
    frc_en = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rom_clear();
    model_reset();
    #1 reset = 1'b1;
    #2 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_retired", retired, 32'h0);

    // ADDI then HALT
    rom_clear();
    rom[0] = 16'h3045;
    rom[1] = 16'hFFFF;
    do_reset();
    do_step(1'b0, 1'b0);
    do_step(1'b0, 1'b0);
    peek("addi_r1", 3'd1, 16'd5);
    chk("addi_model_r1", 32'(m_regs[1]), 32'd5);
    chk("halt_pc", 32'(pc), 32'h2);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_busy", 32'(busy), 32'h0);
`ifdef RISC_CORE_RETIRE_CNT_EN
    chk("halt_retired", retired, 32'd2);
`endif
    do_step(1'b0, 1'b0);  // ignored in HALT
    @(negedge clk);
    chk("halt_stuck_pc", 32'(pc), 32'h2);

    // ALU coverage
    rom_clear();
    rom[0] = 16'h307D;  // addi r1,r0,-3
    rom[1] = 16'h3084;  // addi r2,r0,4
    rom[2] = 16'h1298;  // add  r3
    rom[3] = 16'h12A1;  // sub  r4
    rom[4] = 16'h12AA;  // and  r5
    rom[5] = 16'h12B3;  // or   r6
    rom[6] = 16'h12BC;  // slt  r7
    rom[7] = 16'h12BD;  // sltu r7
    rom[8] = 16'h129E;  // funct 110: no write
    do_reset();
    repeat (7) do_step(1'b0, 1'b0);
    peek("alu_add", 3'd3, 16'h0001);
    peek("alu_sub", 3'd4, 16'hFFF9);
    peek("alu_and", 3'd5, 16'h0004);
    peek("alu_or",  3'd6, 16'hFFFD);
    peek("alu_slt", 3'd7, 16'h0001);
    chk("alu_model_sub", 32'(m_regs[4]), 32'hFFF9);
    chk("alu_model_slt", 32'(m_regs[7]), 32'h1);
    do_step(1'b0, 1'b0);
    peek("alu_sltu", 3'd7, 16'h0000);
    do_step(1'b0, 1'b0);
    peek("alu_nop_r3", 3'd3, 16'h0001);
    @(negedge clk);
    chk("alu_nop_pc", 32'(pc), 32'd18);

    // Branches
    rom_clear();
    rom[0] = 16'h3045;  // addi r1,r0,5
    rom[2] = 16'h523F;  // bneq r1,r0,-1
    do_reset();
    repeat (2) do_step(1'b0, 1'b0);
    do_step(1'b0, 1'b0);
    @(negedge clk);
    chk("bneq_taken_pc", 32'(pc), 32'd4);
    chk("bneq_model_pc", 32'(m_pc), 32'd4);
    rom[2] = 16'h4242;  // beq r1,r1,+2
    do_step(1'b0, 1'b0);
    @(negedge clk);
    chk("beq_taken_pc", 32'(pc), 32'd10);
    rom_clear();
    rom[2] = 16'h523F;
    do_reset();
    repeat (3) do_step(1'b0, 1'b0);
    @(negedge clk);
    chk("bneq_not_taken_pc", 32'(pc), 32'd6);

    // r0 write discarded, step while busy ignored
    rom_clear();
    rom[0] = 16'h3007;  // addi r0,r0,7
    do_reset();
    do_step(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    peek("r0_zero", 3'd0, 16'h0000);
    chk("step_ignore_pc", 32'(pc), 32'd2);
    chk("step_ignore_busy", 32'(busy), 32'd0);

    // Wrap-around over ROM depth
    rom_clear();
    do_reset();
    repeat (17) do_step(1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_pc", 32'(pc), 32'd34);
    chk("wrap_imem_addr", 32'(imem_addr), 32'd1);

    // Reset during EXEC aborts the instruction
    rom_clear();
    rom[0] = 16'h3045;
    do_reset();
    do_step(1'b0, 1'b1);
    peek("abort_r1", 3'd1, 16'h0000);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    do_step(1'b0, 1'b0);
    peek("reexec_r1", 3'd1, 16'd5);
    chk("reexec_pc", 32'(pc), 32'd2);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
